dds_spi_seq: RTL and testbench

//  Parametrised SPI command engine for DDS register access; successor to the single-word vioRW/vioData/vioStart path in DDS_Top.

---
 rtl/dds_spi_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_dds_spi_seq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_spi_seq.sv
`default_nettype none
// ============================================================================
// Module   : dds_spi_seq
// Purpose  : SPI command engine for DDS register access. Serialises host
//            read/write frames (mode 0, MSB first) to one of NUM_CS devices
//            and returns captured MISO data. With DDS_SPI_SEQ_EN defined a
//            register table can be replayed in a continuous loop.
// Options  : DDS_SPI_SEQ_EN - build the sequence table and replay logic
// Revision : 1.0 - initial release
// ============================================================================
module dds_spi_seq #(
    parameter int DATA_W    = 32,
    parameter int NUM_CS    = 2,
    parameter int CLK_DIV   = 4,
    parameter int SEQ_DEPTH = 16,
    // derived widths, not meant to be overridden
    parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    parameter int SEQ_AW    = $clog2(SEQ_DEPTH)
) (
    input  logic                   sys_clk,
    input  logic                   rstn_i,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [CS_W-1:0]        cmd_cs,
    input  logic [DATA_W-1:0]      cmd_data,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    input  logic                   seq_wr_en,
    input  logic [SEQ_AW-1:0]      seq_wr_addr,
    input  logic [CS_W+DATA_W-1:0] seq_wr_data,
    input  logic [SEQ_AW:0]        seq_len,
    input  logic                   seq_run,
    output logic                   seq_busy,
    output logic                   spi_sclk,
    output logic [NUM_CS-1:0]      spi_cs_n,
    output logic                   spi_mosi,
    input  logic                   spi_miso
);

    localparam int CNT_W = $clog2(2 * CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] c_HALF_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_PERIOD_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] c_BIT_LAST    = BIT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        r_state;
    logic              r_cmdReady;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bitCnt;
    logic              r_sclk;
    logic              r_mosi;
    logic [NUM_CS-1:0] r_csN;
    logic              r_rw;
    logic [DATA_W-1:0] r_txSh;
    logic [DATA_W-1:0] r_rxSh;
    logic              r_rdValid;
    logic [DATA_W-1:0] r_rdData;

    logic              w_idle;
    logic              w_startHost;
    logic              w_startSeq;
    logic              w_start;
    logic              w_enterIdle;
    logic [CS_W-1:0]   w_seqCs;
    logic [DATA_W-1:0] w_seqData;
    logic [CS_W-1:0]   w_startCs;
    logic [DATA_W-1:0] w_startData;
    logic              w_startRw;
    logic [NUM_CS-1:0] w_csDec;

    // r_cmdReady is low for one cycle after reset, so IDLE only counts once it is up
    assign w_idle      = (r_state == S_IDLE) && r_cmdReady;
    assign w_startHost = w_idle && cmd_valid;
    assign w_start     = w_startHost || w_startSeq;
    assign w_enterIdle = (r_state == S_GAP) && (r_cnt == c_PERIOD_LAST);

    assign w_startCs   = w_startHost ? cmd_cs   : w_seqCs;
    assign w_startData = w_startHost ? cmd_data : w_seqData;
    assign w_startRw   = w_startHost ? cmd_rw   : 1'b0;

    // One-hot active-low select; an out-of-range index leaves every line high
    always_comb begin
        w_csDec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (w_startCs == CS_W'(i)) begin
                w_csDec[i] = 1'b0;
            end
        end
    end

    // Frame FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP, SCLK/MOSI/CS generation
    always_ff @(posedge sys_clk) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_cmdReady <= 1'b0;
            r_cnt      <= '0;
            r_bitCnt   <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_csN      <= '1;
            r_rw       <= 1'b0;
            r_txSh     <= '0;
            r_rxSh     <= '0;
            r_rdValid  <= 1'b0;
            r_rdData   <= '0;
        end else begin
            r_rdValid  <= 1'b0;
            r_cmdReady <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_SETUP;
                        r_cnt    <= '0;
                        r_bitCnt <= '0;
                        r_rw     <= w_startRw;
                        r_csN    <= w_csDec;
                        r_mosi   <= w_startData[DATA_W-1];
                        r_txSh   <= {w_startData[DATA_W-2:0], 1'b0};
                    end else begin
                        r_cmdReady <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_sclk  <= 1'b1;
                        r_rxSh  <= {r_rxSh[DATA_W-2:0], spi_miso};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == c_HALF_LAST) begin
                        // falling edge: present the next bit
                        r_sclk <= 1'b0;
                        r_mosi <= r_txSh[DATA_W-1];
                        r_txSh <= {r_txSh[DATA_W-2:0], 1'b0};
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end else if (r_cnt == c_PERIOD_LAST) begin
                        r_cnt <= '0;
                        if (r_bitCnt == c_BIT_LAST) begin
                            r_state <= S_HOLD;
                        end else begin
                            // rising edge: sample the slave
                            r_sclk   <= 1'b1;
                            r_rxSh   <= {r_rxSh[DATA_W-2:0], spi_miso};
                            r_bitCnt <= r_bitCnt + BIT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                        r_csN   <= '1;
                        r_mosi  <= 1'b0;
                        if (r_rw) begin
                            r_rdValid <= 1'b1;
                            r_rdData  <= r_rxSh;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_PERIOD_LAST) begin
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_cmdReady <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DDS_SPI_SEQ_EN
    logic [CS_W+DATA_W-1:0] r_seqMem [SEQ_DEPTH];
    logic [SEQ_AW-1:0]      r_seqPtr;
    logic                   r_seqBusy;
    logic [SEQ_AW:0]        w_ptrNext;
    logic                   w_seqWrap;

    // Host always wins; the table is only consulted on an otherwise idle cycle
    assign w_startSeq = w_idle && !cmd_valid && seq_run && (seq_len != '0);
    assign w_seqCs    = r_seqMem[r_seqPtr][CS_W+DATA_W-1:DATA_W];
    assign w_seqData  = r_seqMem[r_seqPtr][DATA_W-1:0];
    assign w_ptrNext  = {1'b0, r_seqPtr} + (SEQ_AW+1)'(1);
    // >= also recovers when seq_len is shrunk below the current pointer
    assign w_seqWrap  = (w_ptrNext >= seq_len) || (&r_seqPtr);
    assign seq_busy   = r_seqBusy;

    // Table storage; async read means a same-cycle write is seen one fetch later
    always_ff @(posedge sys_clk) begin
        if (seq_wr_en) begin
            r_seqMem[seq_wr_addr] <= seq_wr_data;
        end
    end

    // Replay pointer and busy flag
    always_ff @(posedge sys_clk) begin
        if (!rstn_i) begin
            r_seqPtr  <= '0;
            r_seqBusy <= 1'b0;
        end else if (w_startSeq) begin
            r_seqBusy <= 1'b1;
            r_seqPtr  <= w_seqWrap ? '0 : r_seqPtr + SEQ_AW'(1);
        end else if ((w_enterIdle || w_idle) && !seq_run) begin
            r_seqBusy <= 1'b0;
            r_seqPtr  <= '0;
        end
    end
`else
    logic w_unusedSeq;

    assign w_startSeq  = 1'b0;
    assign w_seqCs     = '0;
    assign w_seqData   = '0;
    assign seq_busy    = 1'b0;
    assign w_unusedSeq = ^{seq_wr_en, seq_wr_addr, seq_wr_data, seq_len, seq_run, w_enterIdle};
`endif

    assign cmd_ready = r_cmdReady;
    assign rd_valid  = r_rdValid;
    assign rd_data   = r_rdData;
    assign spi_sclk  = r_sclk;
    assign spi_cs_n  = r_csN;
    assign spi_mosi  = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_dds_spi_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_spi_seq
// Purpose  : Self-checking bench for dds_spi_seq (DATA_W=32, NUM_CS=2,
//            CLK_DIV=2). A bus monitor reassembles SPI frames and read
//            returns and compares them against scoreboard queues. Sequence
//            tests run when DDS_SPI_SEQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_spi_seq;

    localparam int DATA_W = 32;
    localparam int NUM_CS = 2;
    localparam int CLK_DIV = 2;
    localparam int c_FRAME_CYC = CLK_DIV * (2 * DATA_W + 4);

    logic        sys_clk = 1'b0;
    logic        rstn_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic        cmd_cs;
    logic [31:0] cmd_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        seq_wr_en;
    logic [3:0]  seq_wr_addr;
    logic [32:0] seq_wr_data;
    logic [4:0]  seq_len;
    logic        seq_run;
    logic        seq_busy;
    logic        spi_sclk;
    logic [1:0]  spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;

    int checks = 0;
    int errors = 0;

    // scoreboard queues: {cs_n, mosi word} per frame, and read words
    logic [33:0] expFrames[$];
    logic [31:0] expReads[$];

    // monitor / slave model state
    logic [31:0] misoWord = 32'h0;
    logic [5:0]  monBits = 6'd0;
    logic [4:0]  misoIdx;
    logic [31:0] monWord = 32'h0;
    logic [1:0]  monCs = 2'b11;
    logic        csBad = 1'b0;
    logic        prevSclk = 1'b0;
    int          frameCount = 0;

    dds_spi_seq #(
        .DATA_W   (DATA_W),
        .NUM_CS   (NUM_CS),
        .CLK_DIV  (CLK_DIV),
        .SEQ_DEPTH(16)
    ) dut (
        .sys_clk    (sys_clk),
        .rstn_i     (rstn_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rw     (cmd_rw),
        .cmd_cs     (cmd_cs),
        .cmd_data   (cmd_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .seq_wr_en  (seq_wr_en),
        .seq_wr_addr(seq_wr_addr),
        .seq_wr_data(seq_wr_data),
        .seq_len    (seq_len),
        .seq_run    (seq_run),
        .seq_busy   (seq_busy),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 sys_clk = ~sys_clk;

    // slave model: bit k of the frame is presented before rise k
    assign misoIdx  = 5'd31 - monBits[4:0];
    assign spi_miso = misoWord[misoIdx];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sample at the falling sys_clk edge, away from DUT updates
    initial begin
        logic [33:0] e;
        logic [31:0] r;
        forever begin
            @(negedge sys_clk);
            if (!rstn_i) begin
                monBits = 6'd0;
                csBad   = 1'b0;
            end else begin
                if (spi_sclk && !prevSclk) begin
                    if (monBits == 6'd0) monCs = spi_cs_n;
                    else if (spi_cs_n !== monCs) csBad = 1'b1;
                    monWord = {monWord[30:0], spi_mosi};
                    monBits = monBits + 6'd1;
                    if (monBits == 6'd32) begin
                        frameCount++;
                        monBits = 6'd0;
                        checks++;
                        if (expFrames.size() == 0) begin
                            errors++;
                            $display("FAIL frame: unexpected frame cs_n=%b word=%h", monCs, monWord);
                        end else begin
                            e = expFrames.pop_front();
                            if ({monCs, monWord} !== e || csBad) begin
                                errors++;
                                $display("FAIL frame: got cs_n=%b word=%h csglitch=%0d expected cs_n=%b word=%h",
                                         monCs, monWord, csBad, e[33:32], e[31:0]);
                            end
                        end
                        csBad = 1'b0;
                    end
                end
                if (rd_valid) begin
                    checks++;
                    if (expReads.size() == 0) begin
                        errors++;
                        $display("FAIL rd_valid: unexpected pulse rd_data=%h", rd_data);
                    end else begin
                        r = expReads.pop_front();
                        if (rd_data !== r) begin
                            errors++;
                            $display("FAIL rd_data: got %h expected %h", rd_data, r);
                        end
                    end
                end
            end
            prevSclk = spi_sclk;
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge sys_clk);
    endtask

    // Issue a host command, hold valid until accepted, optionally check latency
    task automatic hostCmd(input logic rw, input logic cs, input logic [31:0] data,
                           input logic [31:0] miso, input logic [1:0] expCs, input bit chkLat);
        int   n;
        logic rdy;
        misoWord = miso;
        expFrames.push_back({expCs, data});
        if (rw) expReads.push_back(miso);
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_cs    = cs;
        cmd_data  = data;
        n = 0;
        do begin
            rdy = cmd_ready;
            @(posedge sys_clk);
            n++;
        end while (!rdy && n < 2000);
        #1;
        cmd_valid = 1'b0;
        if (!rdy) chk("accept_timeout", 64'(rdy), 64'd1);
        if (chkLat) begin
            n = 0;
            do begin
                @(posedge sys_clk);
                #1;
                n++;
            end while (!cmd_ready && n < 1000);
            chk("ready_latency", 64'(n), 64'(c_FRAME_CYC));
        end
    endtask

    task automatic waitFrames(input int target);
        int n = 0;
        while (frameCount < target && n < 5000) begin
            @(negedge sys_clk);
            n++;
        end
        if (frameCount < target) chk("frame_wait_timeout", 64'(frameCount), 64'(target));
    endtask

    task automatic waitCsN(input logic [1:0] v);
        int n = 0;
        while (spi_cs_n !== v && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        if (spi_cs_n !== v) chk("cs_wait_timeout", 64'(spi_cs_n), 64'(v));
    endtask

    task automatic waitReady(input logic v);
        int n = 0;
        while (cmd_ready !== v && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        if (cmd_ready !== v) chk("ready_wait_timeout", 64'(cmd_ready), 64'(v));
    endtask

    task automatic waitBusyLow();
        int n = 0;
        while (seq_busy !== 1'b0 && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("seq_busy_drop", 64'(seq_busy), 64'd0);
    endtask

    typedef struct {
        logic        rw;
        logic        cs;
        logic [31:0] data;
        logic [31:0] miso;
        logic [1:0]  expCs;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] lastRd;
        int fc0;

        vecs[0] = '{1'b0, 1'b0, 32'h0C120D34, 32'h00000000, 2'b10};
        vecs[1] = '{1'b1, 1'b1, 32'h8A000000, 32'h04000500, 2'b01};
        vecs[2] = '{1'b0, 1'b1, 32'hA5A5FFFF, 32'h00000000, 2'b01};
        vecs[3] = '{1'b1, 1'b0, 32'h81000000, 32'h80000001, 2'b10};
        vecs[4] = '{1'b1, 1'b0, 32'h00000000, 32'hFFFFFFFF, 2'b10};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000, 2'b10};
        vecs[6] = '{1'b1, 1'b1, 32'h12345678, 32'h00000000, 2'b01};

        rstn_i      = 1'b0;
        cmd_valid   = 1'b0;
        cmd_rw      = 1'b0;
        cmd_cs      = 1'b0;
        cmd_data    = 32'h0;
        seq_wr_en   = 1'b0;
        seq_wr_addr = 4'h0;
        seq_wr_data = 33'h0;
        seq_len     = 5'd0;
        seq_run     = 1'b0;

        // reset state
        waitCycles(10);
        #1;
        chk("rst_sclk", 64'(spi_sclk), 64'd0);
        chk("rst_cs_n", 64'(spi_cs_n), 64'b11);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_seq_busy", 64'(seq_busy), 64'd0);
        @(negedge sys_clk);
        rstn_i = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("release_cmd_ready", 64'(cmd_ready), 64'd1);

        // table-driven host frames
        lastRd = 32'h0;
        for (int i = 0; i < 7; i++) begin
            hostCmd(vecs[i].rw, vecs[i].cs, vecs[i].data, vecs[i].miso, vecs[i].expCs, 1'b1);
            if (vecs[i].rw) lastRd = vecs[i].miso;
            waitCycles(2);
            chk("frame_consumed", 64'(expFrames.size()), 64'd0);
            chk("read_consumed", 64'(expReads.size()), 64'd0);
            chk("rd_data_hold", 64'(rd_data), 64'(lastRd));
        end

`ifdef DDS_SPI_SEQ_EN
        // sequence loop A,B,C,A,B,C then stop during C
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            seq_wr_en   = 1'b1;
            seq_wr_addr = 4'(i);
            seq_wr_data = (i == 0) ? {1'b0, 32'h0C120D34} :
                          (i == 1) ? {1'b1, 32'h04000500} : {1'b0, 32'hA5C30F96};
        end
        @(negedge sys_clk);
        seq_wr_en = 1'b0;
        seq_len   = 5'd3;
        for (int k = 0; k < 2; k++) begin
            expFrames.push_back({2'b10, 32'h0C120D34});
            expFrames.push_back({2'b01, 32'h04000500});
            expFrames.push_back({2'b10, 32'hA5C30F96});
        end
        fc0 = frameCount;
        seq_run = 1'b1;
        waitFrames(fc0 + 5);
        waitCsN(2'b10);
        chk("seq_busy_running", 64'(seq_busy), 64'd1);
        seq_run = 1'b0;
        waitBusyLow();
        chk("seq_stop_ready", 64'(cmd_ready), 64'd1);
        chk("seq_stop_frames", 64'(frameCount - fc0), 64'd6);
        waitCycles(300);
        chk("seq_no_more_frames", 64'(frameCount - fc0), 64'd6);
        chk("seq_queue_empty", 64'(expFrames.size()), 64'd0);

        // host frame slipped in between sequence frames, loop resumes at B
        expFrames.push_back({2'b10, 32'h0C120D34});
        fc0 = frameCount;
        @(negedge sys_clk);
        seq_run = 1'b1;
        waitReady(1'b0);
        hostCmd(1'b0, 1'b1, 32'h04000500, 32'h0, 2'b01, 1'b0);
        expFrames.push_back({2'b01, 32'h04000500});
        waitReady(1'b1);
        waitReady(1'b0);
        seq_run = 1'b0;
        waitBusyLow();
        chk("seq_host_frames", 64'(frameCount - fc0), 64'd3);
        waitCycles(300);
        chk("seq_host_no_more", 64'(frameCount - fc0), 64'd3);
        chk("seq_host_queue_empty", 64'(expFrames.size()), 64'd0);
`else
        // sequence build absent: seq inputs must cause no SPI activity
        @(negedge sys_clk);
        seq_wr_en   = 1'b1;
        seq_wr_addr = 4'h0;
        seq_wr_data = {1'b0, 32'h0C120D34};
        @(negedge sys_clk);
        seq_wr_en = 1'b0;
        seq_len   = 5'd3;
        seq_run   = 1'b1;
        fc0 = frameCount;
        waitCycles(300);
        #1;
        chk("noseq_frames", 64'(frameCount - fc0), 64'd0);
        chk("noseq_cs_n", 64'(spi_cs_n), 64'b11);
        chk("noseq_busy", 64'(seq_busy), 64'd0);
        chk("noseq_ready", 64'(cmd_ready), 64'd1);
        seq_run = 1'b0;
`endif

        // reset in the middle of a read frame
        misoWord = 32'hFFFF0000;
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_cs    = 1'b1;
        cmd_data  = 32'hDEADBEEF;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        waitCycles(20);
        fc0 = frameCount;
        @(negedge sys_clk);
        chk("midframe_cs_active", 64'(spi_cs_n), 64'b01);
        rstn_i = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("abort_cs_n", 64'(spi_cs_n), 64'b11);
        chk("abort_sclk", 64'(spi_sclk), 64'd0);
        chk("abort_mosi", 64'(spi_mosi), 64'd0);
        chk("abort_rd_valid", 64'(rd_valid), 64'd0);
        chk("abort_rd_data", 64'(rd_data), 64'd0);
        waitCycles(3);
        @(negedge sys_clk);
        rstn_i = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("abort_release_ready", 64'(cmd_ready), 64'd1);
        waitCycles(200);
        chk("abort_no_frame", 64'(frameCount - fc0), 64'd0);
        chk("abort_mon_idle", 64'(monBits), 64'd0);

        // final scoreboard drain
        chk("final_frames_empty", 64'(expFrames.size()), 64'd0);
        chk("final_reads_empty", 64'(expReads.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
